// File: rtl/seg_serial_drv.sv
// seg_serial_drv: encodes packed hex digits to segment bytes and shifts them out on a divided serial clock
module seg_serial_drv #(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int REFRESH_GAP = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] num_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    start_i,
  input  logic                    auto_en_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    seg_clk_o,
  output logic                    seg_dt_o,
  output logic                    seg_clr_o,
  output logic                    seg_en_o
);
  localparam int FRAME = NUM_DIGITS * 8;
  localparam int DW    = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW    = $clog2(FRAME + 1);
  localparam int GW    = REFRESH_GAP > 1 ? $clog2(REFRESH_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, DONE} state_e;

  state_e           state_q, state_d;
  logic [FRAME-1:0] sr_q, sr_d, frame_enc;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             busy_q, busy_d, done_q, done_d, clk_q, clk_d, dt_q, dt_d, on_q;
  logic             div_end, trig, shifting;

  function automatic logic [7:0] seg_byte(input logic [3:0] n, input logic p, input logic b);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    seg_byte = b ? 8'h00 : {p, s};
    if (ACTIVE_LOW != 0) seg_byte = ~seg_byte;
  endfunction

  assign div_end  = div_q == DW'(CLK_DIV - 1);
  assign trig     = start_i | (auto_en_i & (gap_q == GW'(REFRESH_GAP - 1)));
  assign shifting = state_d == SHIFT_LO || state_d == SHIFT_HI;

  // Encode every digit into the frame image; digit NUM_DIGITS-1 lands in the top byte so it leaves first
  always_comb begin
    frame_enc = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      frame_enc[8*i +: 8] = seg_byte(num_i[4*i +: 4], dp_i[i], blank_i[i]);
  end

  // Next-state logic; outputs are derived from the next state so they can be registered without lag
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = '0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = SHIFT_LO;
          sr_d    = frame_enc;
          div_d   = '0;
          bit_d   = BW'(FRAME);
        end else if (auto_en_i) begin
          gap_d = gap_q + 1'b1;
        end
      end
      SHIFT_LO: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sr_d    = sr_q << 1;
          bit_d   = bit_q - 1'b1;
          state_d = bit_q == BW'(1) ? DONE : SHIFT_LO;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = shifting;
    done_d = state_d == DONE;
    clk_d  = state_d == SHIFT_HI;
    dt_d   = shifting ? sr_d[FRAME-1] : 1'b1;
  end

  // State, datapath and output registers; reset aborts any frame in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clk_q   <= 1'b0;
      dt_q    <= 1'b1;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clk_q   <= clk_d;
      dt_q    <= dt_d;
      on_q    <= 1'b1;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign seg_clk_o = clk_q;
  assign seg_dt_o  = dt_q;
  assign seg_clr_o = on_q;
  assign seg_en_o  = on_q;
endmodule
